// File: rtl/xadac_pkg.sv
// Shared XADAC datapath types, widths and arithmetic helpers used by the
// int8 dot-product unit and its reduction tree.
package xadac_pkg;

   localparam int ElemWidth   = 8;
   localparam int VectorWidth = 128;
   localparam int SumWidth    = 32;
   localparam int IdWidth     = 4;
   localparam int NumLanes    = VectorWidth / ElemWidth;
   localparam int ProdWidth   = 2 * ElemWidth;
   localparam int DotWidth    = ProdWidth + $clog2(NumLanes);

   typedef logic signed [ElemWidth-1:0] ElemT;
   typedef logic        [VectorWidth-1:0] VectorT;
   typedef logic signed [SumWidth-1:0]  SumT;
   typedef logic        [IdWidth-1:0]   IdT;
   typedef logic signed [ProdWidth-1:0] ProdT;
   typedef logic signed [DotWidth-1:0]  DotT;

   // Signed product of lane k of two packed operand vectors.
   function automatic ProdT lane_mul(input VectorT a, input VectorT b, input int k);
      ElemT w_a;
      ElemT w_b;
      w_a = ElemT'(a[k*ElemWidth +: ElemWidth]);
      w_b = ElemT'(b[k*ElemWidth +: ElemWidth]);
      return ProdT'(w_a) * ProdT'(w_b);
   endfunction

   function automatic SumT add_wrap(input SumT a, input SumT b);
      return a + b;
   endfunction

   // One guard bit is enough: disagreement between the top two bits of the
   // widened sum means the true result left the SumT range.
   function automatic SumT add_sat(input SumT a, input SumT b);
      logic [SumWidth:0] w_s;
      w_s = {a[SumWidth-1], a} + {b[SumWidth-1], b};
      if (w_s[SumWidth] != w_s[SumWidth-1]) begin
         if (w_s[SumWidth]) begin
            return {1'b1, {(SumWidth-1){1'b0}}};
         end else begin
            return {1'b0, {(SumWidth-1){1'b1}}};
         end
      end else begin
         return w_s[SumWidth-1:0];
      end
   endfunction

endpackage

// File: rtl/xadac_adder_tree.sv
// Combinational signed reduction of NumLanes products into one DotT value.
module xadac_adder_tree
   import xadac_pkg::*;
(
   input  ProdT prod_i [NumLanes],
   output DotT  dot_o
);

   DotT w_dot;

   // Pairwise tree; every node is held at full dot width so no level can overflow.
   always_comb begin
      DotT w_lvl [NumLanes];
      for (int i = 0; i < NumLanes; i++) begin
         w_lvl[i] = DotT'(prod_i[i]);
      end
      for (int n = NumLanes / 2; n >= 1; n = n / 2) begin
         for (int i = 0; i < n; i++) begin
            w_lvl[i] = w_lvl[2*i] + w_lvl[2*i+1];
         end
      end
      w_dot = w_lvl[0];
   end

   assign dot_o = w_dot;

endmodule

// File: rtl/xadac_vdot.sv
// Three-stage int8 dot-product-accumulate with valid/ready flow control.
// Build option XADAC_VDOT_SAT_EN: saturating final accumulate instead of wrap.
module xadac_vdot
   import xadac_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [IdWidth-1:0]     req_id_i,
   input  logic [VectorWidth-1:0] req_vs1_i,
   input  logic [VectorWidth-1:0] req_vs2_i,
   input  logic [SumWidth-1:0]    req_acc_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [IdWidth-1:0]     rsp_id_o,
   output logic [SumWidth-1:0]    rsp_sum_o,
   output logic                   busy_o
);

   logic w_adv1, w_adv2, w_adv3;
   logic r_v1, r_v2, r_v3;

   ProdT w_prod [NumLanes];
   ProdT r_prod [NumLanes];
   IdT   r_id1, r_id2, r_id3;
   SumT  r_acc1, r_acc2;
   DotT  w_dot;
   DotT  r_dot2;
   SumT  w_sum3;
   SumT  r_sum3;

   // A stage can take new contents when it is empty or its occupant moves on.
   assign w_adv3 = rsp_ready_i || !r_v3;
   assign w_adv2 = w_adv3 || !r_v2;
   assign w_adv1 = w_adv2 || !r_v1;

   // Lane multipliers feeding the S1 register.
   always_comb begin
      for (int k = 0; k < NumLanes; k++) begin
         w_prod[k] = lane_mul(req_vs1_i, req_vs2_i, k);
      end
   end

   xadac_adder_tree u_tree (
      .prod_i (r_prod),
      .dot_o  (w_dot)
   );

   // Final accumulate of the reduced dot value into the request accumulator.
   always_comb begin
`ifdef XADAC_VDOT_SAT_EN
      w_sum3 = add_sat(SumT'(r_dot2), r_acc2);
`else
      w_sum3 = add_wrap(SumT'(r_dot2), r_acc2);
`endif
   end

   // Stage valid bits.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
      end else begin
         if (w_adv1) r_v1 <= req_valid_i;
         if (w_adv2) r_v2 <= r_v1;
         if (w_adv3) r_v3 <= r_v2;
      end
   end

   // S1: products, tag and accumulator of the accepted request.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < NumLanes; k++) r_prod[k] <= '0;
         r_id1  <= '0;
         r_acc1 <= '0;
      end else if (w_adv1 && req_valid_i) begin
         for (int k = 0; k < NumLanes; k++) r_prod[k] <= w_prod[k];
         r_id1  <= req_id_i;
         r_acc1 <= SumT'(req_acc_i);
      end
   end

   // S2: reduced dot value.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_dot2 <= '0;
         r_id2  <= '0;
         r_acc2 <= '0;
      end else if (w_adv2 && r_v1) begin
         r_dot2 <= w_dot;
         r_id2  <= r_id1;
         r_acc2 <= r_acc1;
      end
   end

   // S3: result register, held while the consumer stalls.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sum3 <= '0;
         r_id3  <= '0;
      end else if (w_adv3 && r_v2) begin
         r_sum3 <= w_sum3;
         r_id3  <= r_id2;
      end
   end

   assign req_ready_o = w_adv1;
   assign rsp_valid_o = r_v3;
   assign rsp_id_o    = r_id3;
   assign rsp_sum_o   = r_sum3;
   assign busy_o      = r_v1 | r_v2 | r_v3;

endmodule

// File: tb/tb_xadac_vdot.sv
// Self-checking bench for xadac_vdot: in-order scoreboard model plus directed cases.
module tb_xadac_vdot;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready_o;
   logic [3:0]   req_id = 4'd0;
   logic [127:0] req_vs1 = 128'd0;
   logic [127:0] req_vs2 = 128'd0;
   logic [31:0]  req_acc = 32'd0;
   logic         rsp_valid_o;
   logic         rsp_ready = 1'b1;
   logic [3:0]   rsp_id_o;
   logic [31:0]  rsp_sum_o;
   logic         busy_o;

   always #5 clk = ~clk;

   xadac_vdot dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready_o),
      .req_id_i    (req_id),
      .req_vs1_i   (req_vs1),
      .req_vs2_i   (req_vs2),
      .req_acc_i   (req_acc),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready),
      .rsp_id_o    (rsp_id_o),
      .rsp_sum_o   (rsp_sum_o),
      .busy_o      (busy_o)
   );

   int total = 0;
   int bad = 0;
   int ncyc = 0;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] sum;
      int          cyc;
   } exp_t;

   exp_t       exp_q[$];
   logic [3:0] drained_q[$];
   logic       m_valid;
   logic       m_ready;
   exp_t       e_new;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   // Reference: plain integer dot product plus accumulator.
   function automatic logic [31:0] ref_sum(input logic [127:0] a, input logic [127:0] b,
                                           input logic [31:0] acc);
      longint s;
      byte    x;
      byte    y;
      s = longint'($signed(acc));
      for (int k = 0; k < 16; k++) begin
         x = a[8*k +: 8];
         y = b[8*k +: 8];
         s += longint'(x) * longint'(y);
      end
`ifdef XADAC_VDOT_SAT_EN
      if (s > 64'sh7FFFFFFF) return 32'h7FFFFFFF;
      if (s < -64'sh80000000) return 32'h80000000;
`endif
      return s[31:0];
   endfunction

   function automatic logic [127:0] fill(input logic [7:0] b);
      return {16{b}};
   endfunction

   // Compare process: the oldest in-flight request shows up three cycles after
   // its accept cycle; capacity is three entries.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         chk("rst_rsp_valid", rsp_valid_o, 1'b0);
         chk("rst_busy", busy_o, 1'b0);
      end else begin
         m_valid = (exp_q.size() > 0) && (ncyc - exp_q[0].cyc >= 3);
         m_ready = rsp_ready || (exp_q.size() < 3);
         chk("rsp_valid", rsp_valid_o, m_valid);
         chk("busy", busy_o, exp_q.size() > 0);
         chk("req_ready", req_ready_o, m_ready);
         if (m_valid) begin
            chk("rsp_id", rsp_id_o, exp_q[0].id);
            chk("rsp_sum", rsp_sum_o, exp_q[0].sum);
            if (rsp_ready) begin
               drained_q.push_back(rsp_id_o);
               void'(exp_q.pop_front());
            end
         end
         if (req_valid && m_ready) begin
            e_new.id  = req_id;
            e_new.sum = ref_sum(req_vs1, req_vs2, req_acc);
            e_new.cyc = ncyc;
            exp_q.push_back(e_new);
         end
      end
      ncyc++;
   end

   task automatic rand_payload(input logic [3:0] id);
      req_id  = id;
      req_vs1 = {$urandom, $urandom, $urandom, $urandom};
      req_vs2 = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
         0:       req_acc = 32'h7FFFFF00 | 32'($urandom_range(0, 255));
         1:       req_acc = 32'h80000000 | 32'($urandom_range(0, 255));
         default: req_acc = $urandom;
      endcase
   endtask

   task automatic directed(input logic [3:0] id, input logic [127:0] a, input logic [127:0] b,
                           input logic [31:0] acc, input logic [31:0] expsum, input string nm);
      bit ok;
      int n;
      @(posedge clk); #1;
      req_valid = 1'b1; req_id = id; req_vs1 = a; req_vs2 = b; req_acc = acc;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk); ok = req_ready_o;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      chk({nm, "_accept"}, ok, 1'b1);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); n++;
         if (rsp_valid_o) break;
      end
      chk({nm, "_latency"}, n, 3);
      chk({nm, "_id"}, rsp_id_o, id);
      chk({nm, "_sum"}, rsp_sum_o, expsum);
   endtask

   // mode 0: consumer always ready, 1: consumer ready at random.
   task automatic stream(input int n, input int mode, input string nm);
      int  sent;
      int  cycles;
      bit  a;
      drained_q.delete();
      sent = 0; cycles = 0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rand_payload(4'($urandom_range(0, 15)));
      req_valid = 1'b1;
      for (int i = 0; i < 2000 && sent < n; i++) begin
         @(negedge clk); a = req_valid && req_ready_o;
         @(posedge clk); #1;
         cycles++;
         if (a) begin
            sent++;
            if (sent < n) rand_payload(4'($urandom_range(0, 15)));
            else req_valid = 1'b0;
         end
         if (mode != 0) rsp_ready = 1'($urandom_range(0, 1));
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      chk({nm, "_sent"}, sent, n);
      if (mode == 0) chk({nm, "_one_per_cycle"}, cycles, n);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!busy_o) break;
      end
      chk({nm, "_drained"}, drained_q.size(), n);
   endtask

   initial begin
      bit a;
      int nacc;

      repeat (2) @(negedge clk);
      chk("reset_rsp_sum", rsp_sum_o, 32'h0);
      chk("reset_rsp_id", rsp_id_o, 4'h0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", req_ready_o, 1'b1);

      // Hand-computed values pin the reference function.
      chk("pin_ones", ref_sum(fill(8'h01), fill(8'h01), 32'd0), 32'h00000010);
      chk("pin_minmin", ref_sum(fill(8'h80), fill(8'h80), 32'd5), 32'h00040005);
      chk("pin_maxmin", ref_sum(fill(8'h7F), fill(8'h80), 32'd0), 32'hFFFC0800);

      directed(4'd3, fill(8'h01), fill(8'h01), 32'd0, 32'h00000010, "ones");
      directed(4'd7, fill(8'h80), fill(8'h80), 32'd5, 32'h00040005, "minmin");
      directed(4'd9, fill(8'h7F), fill(8'h80), 32'd0, 32'hFFFC0800, "maxmin");
`ifdef XADAC_VDOT_SAT_EN
      directed(4'd2, fill(8'h01), fill(8'h01), 32'h7FFFFFF0, 32'h7FFFFFFF, "ovf");
`else
      directed(4'd2, fill(8'h01), fill(8'h01), 32'h7FFFFFF0, 32'h80000000, "ovf");
`endif

      // Backpressure: four requests, consumer stalled.
      repeat (3) @(posedge clk);
      #1;
      drained_q.delete();
      rsp_ready = 1'b0;
      nacc = 0;
      rand_payload(4'd1);
      req_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); a = req_valid && req_ready_o;
         @(posedge clk); #1;
         if (a) begin
            nacc++;
            if (nacc < 4) rand_payload(4'(nacc + 1));
            else req_valid = 1'b0;
         end
      end
      chk("bp_accepted", nacc, 3);
      chk("bp_ready_low", req_ready_o, 1'b0);
      rsp_ready = 1'b1;
      for (int i = 0; i < 20 && nacc < 4; i++) begin
         @(negedge clk); a = req_valid && req_ready_o;
         @(posedge clk); #1;
         if (a) begin
            nacc++;
            req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!busy_o) break;
      end
      chk("bp_count", drained_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < drained_q.size()) chk("bp_order", drained_q[i], 4'(i + 1));
      end

      stream(32, 0, "stream");
      stream(32, 1, "toggle");

      // Reset with three entries in flight.
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      nacc = 0;
      rand_payload(4'd6);
      req_valid = 1'b1;
      for (int i = 0; i < 10 && nacc < 3; i++) begin
         @(negedge clk); a = req_valid && req_ready_o;
         @(posedge clk); #1;
         if (a) nacc++;
      end
      req_valid = 1'b0;
      chk("pre_rst_busy", busy_o, 1'b1);
      chk("pre_rst_valid", rsp_valid_o, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", rsp_valid_o, 1'b0);
      chk("mid_rst_busy", busy_o, 1'b0);
      chk("mid_rst_sum", rsp_sum_o, 32'h0);
      chk("mid_rst_id", rsp_id_o, 4'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      drained_q.delete();
      directed(4'd5, fill(8'h02), fill(8'h03), 32'd1, 32'h00000061, "post_rst");
      repeat (3) @(negedge clk);
      chk("post_rst_only_one", drained_q.size(), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
